// File: rtl/branch_resolver.sv
// Control-flow resolver: captures a decoded branch/jump, waits for operands,
// resolves direction and target, then returns the next PC and the link write to fetch.
module branch_resolver #(
  parameter int unsigned FLUSH_CYCLES = 32'd1,
  parameter logic [31:0] PC_STEP      = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic [2:0]  fun3,
  input  logic [31:0] imm,
  input  logic [31:0] opc,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  input  logic        opnd_valid,
  output logic [31:0] npc,
  output logic        get_npc,
  output logic        is_busy,
  output logic        link_we,
  output logic [31:0] link_data,
  output logic        misaligned
);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_OPND = 3'd1,
    S_RESOLVE   = 3'd2,
    S_ISSUE     = 3'd3,
    S_FLUSH     = 3'd4
  } state_t;

  state_t      state_r, state_s;
  logic [6:0]  opcode_r;
  logic [2:0]  fun3_r;
  logic [31:0] imm_r, opc_r, rs1_r, rs2_r;
  logic [3:0]  flush_cnt_r;
  logic        capture_s, take_opnd_s, taken_s, is_jump_s, flush_done_s;
  logic [31:0] target_s;

  assign is_jump_s    = (opcode_r == OP_JAL) || (opcode_r == OP_JALR);
  assign flush_done_s = (({1'b0, flush_cnt_r} + 5'd1) >= 5'(FLUSH_CYCLES));

  // Next-state decode and capture strobes
  always_comb begin
    state_s     = state_r;
    capture_s   = 1'b0;
    take_opnd_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if ((opcode == OP_BRANCH) || (opcode == OP_JALR)) begin
          state_s   = S_WAIT_OPND;
          capture_s = 1'b1;
        end else if (opcode == OP_JAL) begin
          state_s   = S_RESOLVE;
          capture_s = 1'b1;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_WAIT_OPND: begin
        if (opnd_valid) begin
          state_s     = S_RESOLVE;
          take_opnd_s = 1'b1;
        end else begin
          state_s = S_WAIT_OPND;
        end
      end
      S_RESOLVE: state_s = S_ISSUE;
      S_ISSUE: begin
        if (FLUSH_CYCLES != 32'd0) begin
          state_s = S_FLUSH;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_FLUSH: begin
        if (flush_done_s) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_FLUSH;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // Branch direction from the latched operands
  always_comb begin
    taken_s = 1'b0;
    case (fun3_r)
      3'b000:  taken_s = (rs1_r == rs2_r);
      3'b001:  taken_s = (rs1_r != rs2_r);
      3'b100:  taken_s = ($signed(rs1_r) <  $signed(rs2_r));
      3'b101:  taken_s = ($signed(rs1_r) >= $signed(rs2_r));
      3'b110:  taken_s = (rs1_r <  rs2_r);
      3'b111:  taken_s = (rs1_r >= rs2_r);
      default: taken_s = 1'b0;
    endcase
  end

  // Target selection; all sums wrap at 32 bits
  always_comb begin
    target_s = opc_r + PC_STEP;
    case (opcode_r)
      OP_JAL:  target_s = opc_r + imm_r;
      OP_JALR: target_s = (rs1_r + imm_r) & 32'hFFFF_FFFE;
      default: begin
        if (taken_s) begin
          target_s = opc_r + imm_r;
        end else begin
          target_s = opc_r + PC_STEP;
        end
      end
    endcase
  end

  // State register and flush counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_IDLE;
      flush_cnt_r <= 4'd0;
    end else begin
      state_r <= state_s;
      if ((state_r == S_FLUSH) && (state_s == S_FLUSH)) begin
        flush_cnt_r <= flush_cnt_r + 4'd1;
      end else begin
        flush_cnt_r <= 4'd0;
      end
    end
  end

  // Instruction and operand latches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opcode_r <= 7'd0;
      fun3_r   <= 3'd0;
      imm_r    <= 32'd0;
      opc_r    <= 32'd0;
      rs1_r    <= 32'd0;
      rs2_r    <= 32'd0;
    end else begin
      if (capture_s) begin
        opcode_r <= opcode;
        fun3_r   <= fun3;
        imm_r    <= imm;
        opc_r    <= opc;
      end
      if (take_opnd_s) begin
        rs1_r <= rs1_val;
        rs2_r <= rs2_val;
      end
    end
  end

  // Registered outputs; the RESOLVE cycle loads the values shown during ISSUE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      npc        <= 32'd0;
      get_npc    <= 1'b0;
      is_busy    <= 1'b0;
      link_we    <= 1'b0;
      link_data  <= 32'd0;
      misaligned <= 1'b0;
    end else begin
      get_npc    <= (state_r == S_RESOLVE);
      link_we    <= (state_r == S_RESOLVE) && is_jump_s;
      misaligned <= (state_r == S_RESOLVE) && target_s[1];
      is_busy    <= (state_s != S_IDLE);
      if (state_r == S_RESOLVE) begin
        npc <= target_s;
      end
      if ((state_r == S_RESOLVE) && is_jump_s) begin
        link_data <= opc_r + PC_STEP;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// Bench for branch_resolver: directed vector table, reset/ignore sequences, and
// randomized transactions checked against a cycle-count + arithmetic reference model.
module tb_branch_resolver;

  localparam int FLUSH = 1;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_ADDI   = 7'b0010011;

  logic        clk, rst;
  logic [6:0]  opcode;
  logic [2:0]  fun3;
  logic [31:0] imm, opc, rs1_val, rs2_val;
  logic        opnd_valid;
  logic [31:0] npc, link_data;
  logic        get_npc, is_busy, link_we, misaligned;

  int errors = 0;
  int checks = 0;

  branch_resolver #(.FLUSH_CYCLES(FLUSH), .PC_STEP(32'd4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .fun3(fun3), .imm(imm), .opc(opc),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .opnd_valid(opnd_valid),
    .npc(npc), .get_npc(get_npc), .is_busy(is_busy), .link_we(link_we),
    .link_data(link_data), .misaligned(misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] im;
    logic [31:0] pc;
    logic [31:0] r1;
    logic [31:0] r2;
    int          wait_n;
    logic [31:0] e_npc;
    logic        e_lwe;
    logic [31:0] e_ldata;
    logic        e_mis;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference: RISC-V branch semantics computed with wide integer arithmetic
  function automatic logic [31:0] ref_npc(input logic [6:0] op, input logic [2:0] f3,
                                          input logic [31:0] im, input logic [31:0] pc,
                                          input logic [31:0] r1, input logic [31:0] r2);
    longint s1, s2, u1, u2, sum;
    bit take;
    s1 = longint'($signed(r1));
    s2 = longint'($signed(r2));
    u1 = longint'({32'd0, r1});
    u2 = longint'({32'd0, r2});
    case (f3)
      3'd0:    take = (u1 == u2);
      3'd1:    take = (u1 != u2);
      3'd4:    take = (s1 < s2);
      3'd5:    take = (s1 >= s2);
      3'd6:    take = (u1 < u2);
      3'd7:    take = (u1 >= u2);
      default: take = 1'b0;
    endcase
    if (op == OP_JAL) begin
      sum = (longint'({32'd0, pc}) + longint'({32'd0, im})) % 64'sh1_0000_0000;
    end else if (op == OP_JALR) begin
      sum = (u1 + longint'({32'd0, im})) % 64'sh1_0000_0000;
      sum = sum - (sum % 2);
    end else if (take) begin
      sum = (longint'({32'd0, pc}) + longint'({32'd0, im})) % 64'sh1_0000_0000;
    end else begin
      sum = (longint'({32'd0, pc}) + 64'sd4) % 64'sh1_0000_0000;
    end
    return sum[31:0];
  endfunction

  function automatic logic [6:0] rand_ctrl();
    logic [1:0] r;
    r = 2'($urandom_range(0, 2));
    case (r)
      2'd0:    return OP_BRANCH;
      2'd1:    return OP_JALR;
      default: return OP_JAL;
    endcase
  endfunction

  // One transaction, starting #1 after a posedge with the DUT idle
  task automatic run_txn(input string tag, input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] im, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2, input int wait_n,
                         input logic [31:0] e_npc, input logic e_lwe,
                         input logic [31:0] e_ldata, input logic e_mis);
    int  g;
    bit  jal;
    jal = (op == OP_JAL);
    g   = jal ? 2 : 3 + wait_n;
    opcode = op; fun3 = f3; imm = im; opc = pc;
    rs1_val = $urandom; rs2_val = $urandom;
    opnd_valid = 1'($urandom_range(0, 1));
    for (int k = 1; k <= g + FLUSH + 1; k++) begin
      @(posedge clk); #1;
      check({tag, ".is_busy"},    {31'd0, is_busy},    {31'd0, (k <= g + FLUSH)});
      check({tag, ".get_npc"},    {31'd0, get_npc},    {31'd0, (k == g)});
      check({tag, ".link_we"},    {31'd0, link_we},    {31'd0, (k == g) && e_lwe});
      check({tag, ".misaligned"}, {31'd0, misaligned}, {31'd0, (k == g) && e_mis});
      if (k == g) begin
        check({tag, ".npc"}, npc, e_npc);
        if (e_lwe) check({tag, ".link_data"}, link_data, e_ldata);
      end
      fun3 = 3'($urandom); imm = $urandom; opc = $urandom;
      opcode = (k < g + FLUSH + 1) ? rand_ctrl() : OP_ADDI;
      if (!jal && (k == 1 + wait_n)) begin
        opnd_valid = 1'b1; rs1_val = r1; rs2_val = r2;
      end else if (!jal && (k <= wait_n)) begin
        opnd_valid = 1'b0; rs1_val = $urandom; rs2_val = $urandom;
      end else begin
        opnd_valid = 1'($urandom_range(0, 1)); rs1_val = $urandom; rs2_val = $urandom;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".npc"},        npc,                    32'd0);
    check({tag, ".get_npc"},    {31'd0, get_npc},       32'd0);
    check({tag, ".is_busy"},    {31'd0, is_busy},       32'd0);
    check({tag, ".link_we"},    {31'd0, link_we},       32'd0);
    check({tag, ".link_data"},  link_data,              32'd0);
    check({tag, ".misaligned"}, {31'd0, misaligned},    32'd0);
  endtask

  initial begin
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] im, pc, r1, r2, en;
    int          wn;

    vecs[0] = '{"beq_eq",   OP_BRANCH, 3'b000, 32'h20,       32'h100,       32'h5,        32'h5,        0, 32'h120,  1'b0, 32'h0,  1'b0};
    vecs[1] = '{"blt_tk",   OP_BRANCH, 3'b100, 32'hFFFFFFF8, 32'h100,       32'hFFFFFFFF, 32'h1,        0, 32'hF8,   1'b0, 32'h0,  1'b0};
    vecs[2] = '{"bltu_nt",  OP_BRANCH, 3'b110, 32'hFFFFFFF8, 32'h100,       32'hFFFFFFFF, 32'h1,        0, 32'h104,  1'b0, 32'h0,  1'b0};
    vecs[3] = '{"jalr_w5",  OP_JALR,   3'b000, 32'h3,        32'h40,        32'h1000,     32'h0,        5, 32'h1002, 1'b1, 32'h44, 1'b1};
    vecs[4] = '{"jal_wrap", OP_JAL,    3'b000, 32'h8,        32'hFFFFFFFC,  32'h0,        32'h0,        0, 32'h4,    1'b1, 32'h0,  1'b0};
    vecs[5] = '{"f3_010",   OP_BRANCH, 3'b010, 32'h40,       32'h200,       32'h7,        32'h7,        0, 32'h204,  1'b0, 32'h0,  1'b0};
    vecs[6] = '{"f3_011",   OP_BRANCH, 3'b011, 32'h40,       32'h200,       32'h7,        32'h7,        1, 32'h204,  1'b0, 32'h0,  1'b0};
    vecs[7] = '{"bge_nt",   OP_BRANCH, 3'b101, 32'h10,       32'h100,       32'h80000000, 32'h7FFFFFFF, 0, 32'h104,  1'b0, 32'h0,  1'b0};
    vecs[8] = '{"bgeu_tk",  OP_BRANCH, 3'b111, 32'h10,       32'h100,       32'h80000000, 32'h7FFFFFFF, 2, 32'h110,  1'b0, 32'h0,  1'b0};
    vecs[9] = '{"bne_back", OP_BRANCH, 3'b001, 32'hFFFFFF00, 32'h300,       32'h1,        32'h2,        0, 32'h200,  1'b0, 32'h0,  1'b0};

    rst = 1'b1; opcode = OP_ADDI; fun3 = 3'd0; imm = 32'd0; opc = 32'd0;
    rs1_val = 32'd0; rs2_val = 32'd0; opnd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      run_txn(vecs[i].name, vecs[i].op, vecs[i].f3, vecs[i].im, vecs[i].pc, vecs[i].r1,
              vecs[i].r2, vecs[i].wait_n, vecs[i].e_npc, vecs[i].e_lwe, vecs[i].e_ldata,
              vecs[i].e_mis);
    end

    // Non-control opcodes are ignored
    for (int k = 0; k < 4; k++) begin
      opcode = (k == 0) ? OP_ADDI : 7'($urandom_range(0, 16'h3F));
      opnd_valid = 1'b1;
      @(posedge clk); #1;
      check("addi.is_busy", {31'd0, is_busy}, 32'd0);
      check("addi.get_npc", {31'd0, get_npc}, 32'd0);
    end

    // Reset while waiting for operands drops the instruction
    opcode = OP_BRANCH; fun3 = 3'd0; opc = 32'h500; imm = 32'h8; opnd_valid = 1'b0;
    @(posedge clk); #1;
    opcode = OP_ADDI;
    check("rstw.busy_before", {31'd0, is_busy}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_all_zero("rstw.async");
    @(posedge clk); #1;
    rst = 1'b0; opnd_valid = 1'b1; rs1_val = 32'd1; rs2_val = 32'd1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check("rstw.get_npc", {31'd0, get_npc}, 32'd0);
      check("rstw.is_busy", {31'd0, is_busy}, 32'd0);
    end
    opnd_valid = 1'b0;

    // Randomized transactions against the reference model
    for (int t = 0; t < 40; t++) begin
      op = rand_ctrl();
      f3 = 3'($urandom);
      im = ($urandom_range(0, 1) == 0) ? 32'($signed(12'($urandom))) : $urandom;
      pc = $urandom;
      r1 = $urandom;
      r2 = ($urandom_range(0, 3) == 0) ? r1 : $urandom;
      wn = $urandom_range(0, 4);
      en = ref_npc(op, f3, im, pc, r1, r2);
      run_txn($sformatf("rnd%0d", t), op, f3, im, pc, r1, r2, wn, en,
              (op != OP_BRANCH), pc + 32'd4, en[1]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
